// File: rtl/dir_button_conditioner.sv
// dir_button_conditioner: turns the four raw direction buttons into clean one-cycle move pulses.
// Latency: a raw press first sampled at edge 0 pulses after edge 2+DEBOUNCE_CYCLES if uncontended.
// Backpressure: none. Simultaneous presses queue in pending bits and leave one per cycle (up > down > left > right).
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset, clears every flop
//   btn_raw  raw buttons, bit0 up, bit1 down, bit2 left, bit3 right
//   up/down/left/right  registered one-cycle move pulses, at most one high per cycle
//   held     debounced stable level per button, same bit order as btn_raw
//
// Optional feature: define DIR_BTN_REPEAT_EN to auto-repeat a single held direction.
// The first repeat comes REPEAT_DELAY cycles after the press pulse, then one every REPEAT_PERIOD cycles.
// A diagonal hold (more than one held bit) does not repeat.
// Without the macro each debounced press gives exactly one pulse, and REPEAT_DELAY/REPEAT_PERIOD have no effect.

module dir_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic [3:0] held
);

    // Elaboration-time parameter sanity checks.
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cycles
        $error("cycle parameters must be at least 1");
    end

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [3:0]       held_d;
    logic [3:0]       pending;
    logic [3:0]       pulse;
    logic [CNT_W-1:0] cnt [4];

    logic [3:0] rise;
    logic [3:0] fire;
    logic [3:0] ev;
    logic [3:0] req;
    logic [3:0] grant;

    // Synchroniser and per-channel debounce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            held   <= '0;
            held_d <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1     <= btn_raw ^ {4{ACTIVE_LOW}};
            s2     <= s1;
            held_d <= held;
            for (int i = 0; i < 4; i++) begin
                // Any cycle that agrees with the stable level restarts the count.
                // A glitch therefore has to persist DEBOUNCE_CYCLES in a row to flip held.
                if (s2[i] == held[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    held[i] <= s2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = held & ~held_d;

`ifdef DIR_BTN_REPEAT_EN
    localparam int            TW      = CNT_W + 6;
    localparam logic [TW-1:0] RPT_DLY = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RPT_PER = TW'(REPEAT_PERIOD - 1);

    logic [TW-1:0] rpt [4];
    logic          multi_held;

    // Clearing the lowest set bit leaves something only if two or more bits are held.
    assign multi_held = (held & (held - 4'd1)) != 4'd0;

    always_comb begin
        fire = '0;
        for (int i = 0; i < 4; i++) begin
            fire[i] = held[i] && !rise[i] && (rpt[i] == '0) && !multi_held;
        end
    end

    // The timer keeps running during a diagonal hold, so repeats resume on the
    // normal cadence once only one direction is left held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                rpt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!held[i]) begin
                    rpt[i] <= '0;
                end else if (rise[i]) begin
                    rpt[i] <= RPT_DLY;
                end else if (rpt[i] == '0) begin
                    rpt[i] <= RPT_PER;
                end else begin
                    rpt[i] <= rpt[i] - TW'(1);
                end
            end
        end
    end
`else
    assign fire = '0;
`endif

    // New events join the stored ones in this cycle's arbitration, so an
    // uncontended press pulses on the same edge it would have set pending.
    assign ev    = rise | fire;
    assign req   = pending | ev;
    assign grant = req & (~req + 4'd1);   // isolate lowest set bit = highest priority

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            pulse   <= '0;
        end else begin
            pulse <= grant;
            // Requests that lost arbitration wait.
            // A new event arriving while its old one is granted is kept, so the set wins.
            pending <= (req & ~grant) | (pending & ev);
        end
    end

    assign up    = pulse[0];
    assign down  = pulse[1];
    assign left  = pulse[2];
    assign right = pulse[3];

endmodule

// File: tb/tb_dir_button_conditioner.sv
// tb_dir_button_conditioner: directed checks of debounce, edge pulses, priority, reset and auto-repeat.
// Runs with DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5.
// Inputs change 1 ns after the rising edge and outputs are sampled at the same point.

module tb_dir_button_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'b0000;
    logic       up, down, left, right;
    logic [3:0] held;
    logic [3:0] pv;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign pv = {right, left, down, up};

    dir_button_conditioner #(
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (4),
        .ACTIVE_LOW     (1'b0),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .up     (up),
        .down   (down),
        .left   (left),
        .right  (right),
        .held   (held)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        btn_raw = 4'b0000;
        repeat (3) step();
        rst = 1'b0;
    endtask

    int up_at, down_at, right_at;
    int n_up, n_down, n_left, n_right, n_multi;
    int held_seen;
    int dq[$];
    int exp_q[$];

    initial begin
        // Reset state
        #1;
        chk("rst_held", 32'(held), 32'h0);
        chk("rst_pulses", 32'(pv), 32'h0);
        do_reset();

        // Test 2: single press of up
        btn_raw = 4'b0001;
        n_down = 0; n_left = 0; n_right = 0; n_up = 0; up_at = -1;
        for (int k = 0; k <= 14; k++) begin
            step();
            if (k == 8)  chk("t2_held_e8", 32'(held), 32'h0);
            if (k == 9)  chk("t2_held_e9", 32'(held), 32'h1);
            if (up) begin n_up++; if (up_at < 0) up_at = k; end
            n_down  += int'(down);
            n_left  += int'(left);
            n_right += int'(right);
        end
        chk("t2_up_count", 32'(n_up), 32'd1);
        chk("t2_up_edge", 32'(up_at), 32'd10);
        chk("t2_other_pulses", 32'(n_down + n_left + n_right), 32'd0);

        // Test 1: asynchronous reset mid-cycle while up is pulsing
        do_reset();
        btn_raw = 4'b0001;
        repeat (11) step();
        chk("t1_up_before_rst", 32'(up), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("t1_pulses_async", 32'(pv), 32'h0);
        chk("t1_held_async", 32'(held), 32'h0);
        step();
        rst = 1'b0;
        btn_raw = 4'b0000;

        // Test 3: 6-cycle glitch on left is filtered
        do_reset();
        btn_raw = 4'b0100;
        held_seen = 0; n_left = 0;
        for (int k = 0; k < 26; k++) begin
            step();
            if (k == 5) btn_raw = 4'b0000;
            held_seen |= int'(held);
            n_left += int'(pv != 4'b0000);
        end
        chk("t3_held", 32'(held_seen), 32'h0);
        chk("t3_pulses", 32'(n_left), 32'd0);

        // Test 4: up, down, right together -> three consecutive pulses
        do_reset();
        btn_raw = 4'b1011;
        up_at = -1; down_at = -1; right_at = -1;
        n_up = 0; n_down = 0; n_left = 0; n_right = 0; n_multi = 0;
        for (int k = 0; k <= 15; k++) begin
            step();
            if (up)    begin n_up++;    up_at = k;    end
            if (down)  begin n_down++;  down_at = k;  end
            if (right) begin n_right++; right_at = k; end
            n_left += int'(left);
            if ($countones(pv) > 1) n_multi++;
        end
        chk("t4_held", 32'(held), 32'hB);
        chk("t4_up_edge", 32'(up_at), 32'd10);
        chk("t4_down_edge", 32'(down_at), 32'd11);
        chk("t4_right_edge", 32'(right_at), 32'd12);
        chk("t4_counts", 32'(n_up * 100 + n_down * 10 + n_right), 32'd111);
        chk("t4_left", 32'(n_left), 32'd0);
        chk("t4_one_hot", 32'(n_multi), 32'd0);

        // Test 5: reset mid-debounce, button kept held
        do_reset();
        btn_raw = 4'b0001;
        n_up = 0;
        repeat (5) begin
            step();
            n_up += int'(up);
        end
        rst = 1'b1;
        step();
        step();
        chk("t5_held_in_rst", 32'(held), 32'h0);
        rst = 1'b0;
        up_at = -1;
        for (int k = 0; k <= 15; k++) begin
            step();
            if (up) begin n_up++; up_at = k; end
        end
        chk("t5_up_count", 32'(n_up), 32'd1);
        chk("t5_up_edge", 32'(up_at), 32'd10);

        // Test 6: hold down for 50 cycles
        do_reset();
        btn_raw = 4'b0010;
        dq.delete();
        n_multi = 0;
        for (int k = 0; k < 80; k++) begin
            step();
            if (k == 49) btn_raw = 4'b0000;
            if (k == 58) chk("t6_held_e58", 32'(held), 32'h2);
            if (k == 59) chk("t6_held_e59", 32'(held), 32'h0);
            if (down) dq.push_back(k);
            n_multi += int'((pv & 4'b1101) != 4'b0000);
        end
`ifdef DIR_BTN_REPEAT_EN
        exp_q = '{10, 30, 35, 40, 45, 50, 55};
`else
        exp_q = '{10};
`endif
        chk("t6_down_count", 32'(dq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < dq.size()) chk($sformatf("t6_pulse%0d_edge", i), 32'(dq[i]), 32'(exp_q[i]));
        end
        chk("t6_other_pulses", 32'(n_multi), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dir_button_conditioner.md
Name: dir_button_conditioner

Overview:
- Conditions the four raw IO-shield direction buttons (up, down, left, right) into clean single-cycle move pulses for the game loop.
- Chain per button: two-flop synchroniser, then counter-based debounce, then rising-edge detection.
- A pending/priority stage guarantees at most one move pulse per clock.
- Sits between the io_button pins and the game loop's up/down/left/right inputs in the top level.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synchronised input must differ from the stable state before the stable state flips (20 ms at 50 MHz).
- CNT_W, 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- ACTIVE_LOW, 0: 1 inverts raw inputs before the synchroniser.
- REPEAT_DELAY, 25000000: cycles from press pulse to first auto-repeat (used only with the optional feature).
- REPEAT_PERIOD, 10000000: cycles between subsequent auto-repeats (used only with the optional feature).

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous active-high reset
- btn_raw  input  4  raw buttons; bit0 up, bit1 down, bit2 left, bit3 right
- up  output  1  one-cycle move pulse
- down  output  1  one-cycle move pulse
- left  output  1  one-cycle move pulse
- right  output  1  one-cycle move pulse
- held  output  4  debounced stable level per button, same bit order as btn_raw

Behaviour:
- Clocking and reset
  - Single clock domain clk.
  - rst is asynchronous and active-high; it clears every flop immediately.
  - Reset values: up, down, left, right = 0; held = 4'b0000. Sync flops, counters, pending bits and repeat timers = 0.
- Synchroniser
  - s1 <= btn_raw ^ {4{ACTIVE_LOW}}; s2 <= s1.
- Debounce, per channel i
  - If s2[i] == held[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: held[i] <= s2[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at s2 never changes held.
  - The counter saturates by construction and never wraps.
- Edge detect
  - rise[i] = held[i] & ~held_d[i], where held_d is held delayed one cycle.
  - Release produces no pulse.
- Pending/priority
  - pending[i] is set when rise[i] is asserted (or when the repeat timer fires).
  - Each cycle, the lowest-index set pending bit (priority up > down > left > right) is cleared and its output is registered high for exactly one cycle. All other outputs are 0.
  - Simultaneous edges: the lower-priority pulses follow on consecutive cycles. No press is lost.
  - Set and clear of the same bit in one cycle: set wins (the new event is kept).
- Latency
  - Raw edge first sampled at edge 0: s2 is high after edge 1.
  - held rises at edge 1+DEBOUNCE_CYCLES.
  - Pulse is high after edge 2+DEBOUNCE_CYCLES when the channel has no competing pending bits.
- Reset mid-debounce: all progress is discarded. After rst deasserts, a still-pressed button requires a full debounce and then produces one pulse.

Optional Feature:
- Macro: DIR_BTN_REPEAT_EN.
- Defined: each channel has a CNT_W+6-bit repeat timer.
  - Timer loads REPEAT_DELAY-1 on rise[i] and counts down while held[i] == 1.
  - At 0 it sets pending[i] and reloads REPEAT_PERIOD-1.
  - Timer clears when held[i] falls.
  - Repeats are suppressed while more than one held bit is set, so diagonal holds do not auto-move.
- Undefined: no repeat logic; REPEAT_DELAY and REPEAT_PERIOD are ignored. Exactly one pulse per debounced press.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5.
- Test 1: assert rst mid-clock → all outputs 0 before the next edge; held=0000.
- Test 2: btn_raw[0] rises and stays high → held[0]=1 after edge 9, up=1 for exactly the cycle after edge 10, down/left/right stay 0.
- Test 3: btn_raw[2] high for 6 cycles then low → held stays 0000; no pulse.
- Test 4: btn_raw=4'b1011 in the same cycle, held → up, down, right pulse on three consecutive cycles in that order; left never pulses.
- Test 5: hold up, assert rst at cycle 5, release rst, keep holding → exactly one up pulse, 10 cycles after rst release.
- Test 6: with DIR_BTN_REPEAT_EN defined, hold down 50 cycles → initial pulse, then repeats 20 cycles later and every 5 cycles after; 7 pulses total. Without the macro → 1 pulse.
